// File: rtl/rcpu_seq_ctrl.sv
// Multi-cycle sequencer for the R-type datapath: fetches via req/ack, decodes op/func,
// and steps the register file and ALU through EXEC and WB before advancing the PC.
module rcpu_seq_ctrl #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    output logic             imem_req,
    output logic [PC_W-1:0]  pc,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    output logic [4:0]       rd_addr,
    output logic [2:0]       alu_op,
    output logic             alu_latch,
    output logic             rf_we,
    output logic             bad_instr,
    output logic             busy,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dec_legal;
    logic [2:0]       dec_op;

    // The shift-amount field is not used by any supported operation.
    logic unused_shamt;
    assign unused_shamt = ^ir_q[10:6];

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 3'b000;
        if (ir_q[31:26] == 6'b000000) begin
            case (ir_q[5:0])
                6'b100000: begin dec_legal = 1'b1; dec_op = 3'b100; end
                6'b100010: begin dec_legal = 1'b1; dec_op = 3'b101; end
                6'b100100: begin dec_legal = 1'b1; dec_op = 3'b000; end
                6'b100101: begin dec_legal = 1'b1; dec_op = 3'b001; end
                6'b100110: begin dec_legal = 1'b1; dec_op = 3'b010; end
                6'b100111: begin dec_legal = 1'b1; dec_op = 3'b011; end
                6'b101011: begin dec_legal = 1'b1; dec_op = 3'b110; end
                6'b000100: begin dec_legal = 1'b1; dec_op = 3'b111; end
                default:   begin dec_legal = 1'b0; dec_op = 3'b000; end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_op_d = alu_op_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                valid_d = dec_legal;
                if (dec_legal) begin
                    alu_op_d = dec_op;
                    state_d  = StExec;
                end else begin
                    state_d = StWb;
                end
            end
            StExec: begin
                state_d = StWb;
            end
            StWb: begin
                pc_d = pc_q + PC_W'(4);
                if (valid_q) cnt_d = cnt_q + CNT_W'(1);
                state_d = run ? StFetch : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            ir_q     <= '0;
            alu_op_q <= 3'b000;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            alu_op_q <= alu_op_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_req  = (state_q == StFetch);
    assign alu_latch = (state_q == StExec);
    // Writes to r0 are dropped, but the instruction still retires and is counted.
    assign rf_we     = (state_q == StWb) && valid_q && (ir_q[15:11] != 5'd0);
    assign bad_instr = (state_q == StWb) && !valid_q;
    assign busy      = (state_q != StIdle);
    assign pc        = pc_q;
    assign rs_addr   = ir_q[25:21];
    assign rt_addr   = ir_q[20:16];
    assign rd_addr   = ir_q[15:11];
    assign alu_op    = alu_op_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_rcpu_seq_ctrl.sv
// Bench for rcpu_seq_ctrl: directed scenarios then randomized instructions, each checked
// against a per-instruction transaction model (latency, pulses, PC, count, ALU code).
module tb_rcpu_seq_ctrl;

    localparam int unsigned PcW  = 8;
    localparam int unsigned CntW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic            imem_ack;
    logic [31:0]     imem_data;
    logic            imem_req;
    logic [PcW-1:0]  pc;
    logic [4:0]      rs_addr, rt_addr, rd_addr;
    logic [2:0]      alu_op;
    logic            alu_latch, rf_we, bad_instr, busy;
    logic [CntW-1:0] instr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [PcW-1:0]  m_pc;
    logic [CntW-1:0] m_cnt;
    logic [2:0]      m_op;

    rcpu_seq_ctrl #(.PC_W(PcW), .CNT_W(CntW)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .imem_req  (imem_req),
        .pc        (pc),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .alu_op    (alu_op),
        .alu_latch (alu_latch),
        .rf_we     (rf_we),
        .bad_instr (bad_instr),
        .busy      (busy),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output logic ok,
                                       output logic [2:0] code);
        ok   = 1'b0;
        code = 3'b000;
        if (ins[31:26] == 6'd0) begin
            case (ins[5:0])
                6'h20: begin ok = 1'b1; code = 3'd4; end
                6'h22: begin ok = 1'b1; code = 3'd5; end
                6'h24: begin ok = 1'b1; code = 3'd0; end
                6'h25: begin ok = 1'b1; code = 3'd1; end
                6'h26: begin ok = 1'b1; code = 3'd2; end
                6'h27: begin ok = 1'b1; code = 3'd3; end
                6'h2b: begin ok = 1'b1; code = 3'd6; end
                6'h04: begin ok = 1'b1; code = 3'd7; end
                default: ;
            endcase
        end
    endfunction

    // Entered with the DUT in FETCH; returns with the DUT in FETCH again.
    task automatic do_instr(input logic [31:0] ins, input int delay, input logic keep_run);
        logic       ok;
        logic [2:0] code;
        int         cyc, n_lat, n_we, n_bad;
        ref_decode(ins, ok, code);
        for (int i = 0; i < delay; i++) begin
            check("req_wait", imem_req, 1);
            check("pc_wait", pc, m_pc);
            imem_ack  = 1'b0;
            imem_data = $urandom;
            @(negedge clk);
        end
        check("req", imem_req, 1);
        check("pc_fetch", pc, m_pc);
        check("busy_fetch", busy, 1);
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clk);
        cyc = 0; n_lat = 0; n_we = 0; n_bad = 0;
        while (cyc < 10 && busy && !imem_req) begin
            check("fields", {rs_addr, rt_addr, rd_addr}, {ins[25:21], ins[20:16], ins[15:11]});
            n_lat += int'(alu_latch);
            n_we  += int'(rf_we);
            n_bad += int'(bad_instr);
            if (cyc == 1) run = keep_run;
            cyc++;
            imem_ack  = 1'($urandom);
            imem_data = $urandom;
            @(negedge clk);
        end
        check("latency", cyc, ok ? 3 : 2);
        check("alu_latch_cnt", n_lat, ok ? 1 : 0);
        check("rf_we_cnt", n_we, (ok && ins[15:11] != 5'd0) ? 1 : 0);
        check("bad_instr_cnt", n_bad, ok ? 0 : 1);
        if (ok) begin
            m_op  = code;
            m_cnt = m_cnt + 1'b1;
        end
        m_pc = m_pc + 8'd4;
        check("alu_op", alu_op, m_op);
        check("pc_next", pc, m_pc);
        check("instr_cnt", instr_cnt, m_cnt);
        check("after_wb", {busy, imem_req}, keep_run ? 2'b11 : 2'b00);
        if (!keep_run) begin
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("idle_hold", busy, 0);
            end
            run = 1'b1;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_legal();
        logic [5:0]  funcs [8];
        logic [31:0] r;
        funcs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2b, 6'h04};
        r = $urandom;
        return {6'd0, r[25:6], funcs[$urandom_range(7, 0)]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = '0;
        m_pc = '0; m_cnt = '0; m_op = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("rst_outs", {imem_req, alu_latch, rf_we, bad_instr, busy}, 5'b0);
        check("rst_pc", pc, 0);
        check("rst_cnt", instr_cnt, 0);
        check("rst_fields", {rs_addr, rt_addr, rd_addr, alu_op}, 0);
        rst = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        check("idle_no_run", busy, 0);
        run = 1'b1;
        imem_ack = 1'b0;
        @(negedge clk);
        check("enter_fetch", imem_req, 1);

        // add $8,$9,$10 with immediate ack, then with a 3-cycle ack delay
        do_instr(32'h012A4020, 0, 1'b1);
        check("add_rs", rs_addr, 9);
        check("add_rt", rt_addr, 10);
        check("add_rd", rd_addr, 8);
        check("add_op", alu_op, 3'b100);
        do_instr(32'h012A4020, 3, 1'b1);
        // illegal opcode and illegal func
        do_instr(32'h8C000000, 1, 1'b1);
        do_instr(32'h0000002A, 0, 1'b1);
        // sub with rd=0 retires without a write
        do_instr(32'h00220022, 0, 1'b1);
        // run dropped mid-instruction
        do_instr(32'h012A4020, 0, 1'b0);

        // reset during EXEC
        imem_ack = 1'b1; imem_data = 32'h012A4020;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        check("exec_before_rst", alu_latch, 1);
        rst = 1'b1;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_pc", pc, 0);
        @(negedge clk);
        check("rst_no_we", rf_we, 0);
        check("rst_cnt_clear", instr_cnt, 0);
        rst = 1'b0;
        m_pc = '0; m_cnt = '0; m_op = 3'b000;
        @(negedge clk);
        check("restart_fetch", imem_req, 1);

        // 64 legal instructions: pc wraps and the count reaches 64
        for (int i = 0; i < 64; i++) do_instr(rand_legal(), 0, 1'b1);
        check("wrap_pc", pc, 0);
        check("cnt_64", instr_cnt, 64);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] ins;
            ins = ($urandom_range(1, 0) == 1) ? rand_legal() : $urandom;
            do_instr(ins, $urandom_range(3, 0), ($urandom_range(4, 0) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
